// File: rtl/write_back_if.sv
// Stage-input, UART-receive and commit-output bundle of the write-back stage.
// master drives the instruction fields and UART bytes; slave is the stage itself.
interface write_back_if #(
    parameter int unsigned InstMemWidth = 14
);
    logic                    in_valid;
    logic                    reg_write;
    logic [1:0]              mem_to_reg;
    logic [1:0]              branch;
    logic                    uart_to_reg;
    logic [31:0]             read_data;
    logic [31:0]             register_data;
    logic [31:0]             alu_result;
    logic [4:0]              rdist;
    logic [25:0]             inst_index;
    logic [InstMemWidth-1:0] pc;
    logic [InstMemWidth-1:0] pc1;
    logic [InstMemWidth-1:0] pc2;
    logic [7:0]              uart_rx_data;
    logic                    uart_rx_valid;
    logic                    uart_rx_ready;
    logic                    stall;
    logic                    reg_we;
    logic [4:0]              reg_waddr;
    logic [31:0]             reg_wdata;
    logic                    pc_we;
    logic [InstMemWidth-1:0] pc_target;
    logic                    retired;

    modport master (
        output in_valid, reg_write, mem_to_reg, branch, uart_to_reg, read_data,
               register_data, alu_result, rdist, inst_index, pc, pc1, pc2,
               uart_rx_data, uart_rx_valid,
        input  uart_rx_ready, stall, reg_we, reg_waddr, reg_wdata, pc_we, pc_target,
               retired
    );

    modport slave (
        input  in_valid, reg_write, mem_to_reg, branch, uart_to_reg, read_data,
               register_data, alu_result, rdist, inst_index, pc, pc1, pc2,
               uart_rx_data, uart_rx_valid,
        output uart_rx_ready, stall, reg_we, reg_waddr, reg_wdata, pc_we, pc_target,
               retired
    );
endinterface

// File: rtl/write_back.sv
// Final pipeline stage: commits the register write and next PC, optionally gathering
// 1 or 4 little-endian bytes from the UART receiver while stalling upstream.
module write_back #(
    parameter int unsigned InstMemWidth = 14
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    write_back_if.slave   wb_io
);
    typedef enum logic [0:0] {StIdle, StUartWait} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    word_q, word_d;
    logic [31:0]             acc_q, acc_d;
    logic                    lat_we_q, lat_we_d;
    logic [4:0]              lat_waddr_q, lat_waddr_d;
    logic [InstMemWidth-1:0] lat_tgt_q, lat_tgt_d;
    logic                    reg_we_q, reg_we_d;
    logic [4:0]              reg_waddr_q, reg_waddr_d;
    logic [31:0]             reg_wdata_q, reg_wdata_d;
    logic                    pc_we_q, pc_we_d;
    logic [InstMemWidth-1:0] pc_target_q, pc_target_d;
    logic                    retired_q, retired_d;
    logic                    stall_q, stall_d;
    logic                    ready_q, ready_d;

    logic                    accept, wr_en, last_byte;
    logic [31:0]             sel_wdata, acc_ins;
    logic [InstMemWidth-1:0] next_pc;

    always_comb begin
        accept = wb_io.in_valid && !stall_q && (state_q == StIdle);
        wr_en  = wb_io.reg_write && (wb_io.rdist != 5'd0);

        unique case (wb_io.mem_to_reg)
            2'b00:   sel_wdata = wb_io.alu_result;
            2'b01:   sel_wdata = wb_io.read_data;
            2'b10:   sel_wdata = {{(32 - InstMemWidth){1'b0}}, wb_io.pc1};
            default: sel_wdata = wb_io.register_data;
        endcase

        unique case (wb_io.branch)
            2'b00:   next_pc = wb_io.pc1;
            2'b01:   next_pc = (wb_io.alu_result == 32'd0) ? wb_io.pc2 : wb_io.pc1;
            2'b10:   next_pc = wb_io.inst_index[InstMemWidth-1:0];
            default: next_pc = wb_io.register_data[InstMemWidth-1:0];
        endcase

        acc_ins = acc_q;
        acc_ins[{cnt_q, 3'b000} +: 8] = wb_io.uart_rx_data;
        last_byte = word_q ? (cnt_q == 2'd3) : 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        acc_d       = acc_q;
        lat_we_d    = lat_we_q;
        lat_waddr_d = lat_waddr_q;
        lat_tgt_d   = lat_tgt_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        pc_we_d     = 1'b0;
        pc_target_d = pc_target_q;
        retired_d   = 1'b0;
        stall_d     = stall_q;
        ready_d     = ready_q;

        unique case (state_q)
            StIdle: begin
                if (accept && wb_io.uart_to_reg) begin
                    lat_we_d    = wr_en;
                    lat_waddr_d = wb_io.rdist;
                    lat_tgt_d   = next_pc;
                    acc_d       = 32'd0;
                    cnt_d       = 2'd0;
                    word_d      = wb_io.mem_to_reg[0];
                    stall_d     = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = StUartWait;
                end else if (accept) begin
                    reg_we_d    = wr_en;
                    reg_waddr_d = wb_io.rdist;
                    reg_wdata_d = sel_wdata;
                    pc_we_d     = 1'b1;
                    pc_target_d = next_pc;
                    retired_d   = 1'b1;
                end
            end
            StUartWait: begin
                // ready is high throughout this state, so valid alone means a byte is taken
                if (wb_io.uart_rx_valid) begin
                    acc_d = acc_ins;
                    if (last_byte) begin
                        reg_we_d    = lat_we_q;
                        reg_waddr_d = lat_waddr_q;
                        reg_wdata_d = acc_ins;
                        pc_we_d     = 1'b1;
                        pc_target_d = lat_tgt_q;
                        retired_d   = 1'b1;
                        cnt_d       = 2'd0;
                        stall_d     = 1'b0;
                        ready_d     = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            word_q      <= 1'b0;
            acc_q       <= 32'd0;
            lat_we_q    <= 1'b0;
            lat_waddr_q <= 5'd0;
            lat_tgt_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= 5'd0;
            reg_wdata_q <= 32'd0;
            pc_we_q     <= 1'b0;
            pc_target_q <= '0;
            retired_q   <= 1'b0;
            stall_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            lat_we_q    <= lat_we_d;
            lat_waddr_q <= lat_waddr_d;
            lat_tgt_q   <= lat_tgt_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            pc_we_q     <= pc_we_d;
            pc_target_q <= pc_target_d;
            retired_q   <= retired_d;
            stall_q     <= stall_d;
            ready_q     <= ready_d;
        end
    end

    assign wb_io.reg_we        = reg_we_q;
    assign wb_io.reg_waddr     = reg_waddr_q;
    assign wb_io.reg_wdata     = reg_wdata_q;
    assign wb_io.pc_we         = pc_we_q;
    assign wb_io.pc_target     = pc_target_q;
    assign wb_io.retired       = retired_q;
    assign wb_io.stall         = stall_q;
    assign wb_io.uart_rx_ready = ready_q;

    // The current PC and the high jump-field bits play no part in commit.
    logic unused_inputs;
    assign unused_inputs = ^{wb_io.pc, wb_io.inst_index[25:InstMemWidth]};
endmodule

// File: tb/tb_write_back.sv
// Randomised and directed bench for write_back; a transaction-level model predicts each
// commit and a monitor pops and compares every retired pulse against it.
module tb_write_back;
    localparam int unsigned W = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    write_back_if #(.InstMemWidth(W)) bus ();
    write_back #(.InstMemWidth(W)) dut (.clk_i(clk), .rst_ni(rst_n), .wb_io(bus));

    typedef struct packed {
        logic v; logic rw; logic [1:0] m2r; logic [1:0] br; logic u;
        logic [31:0] rd; logic [31:0] regd; logic [31:0] alu;
        logic [4:0] rdist; logic [25:0] idx; logic [W-1:0] pc; logic [W-1:0] pc1;
        logic [W-1:0] pc2;
    } instr_t;

    typedef struct packed {
        logic we; logic [4:0] waddr; logic [31:0] wdata; logic [W-1:0] tgt; int cyc;
    } exp_t;

    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    exp_t       sb[$];
    logic [7:0] byte_q[$];
    logic [7:0] next_bytes[$];
    bit         busy = 1'b0;
    int         nb_need, nb_got;
    logic [31:0] acc_val;
    exp_t       pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] model_pc(input instr_t i);
        case (i.br)
            2'd0:    return i.pc1;
            2'd1:    return (i.alu == 32'd0) ? i.pc2 : i.pc1;
            2'd2:    return i.idx[W-1:0];
            default: return i.regd[W-1:0];
        endcase
    endfunction

    function automatic logic [31:0] model_data(input instr_t i);
        case (i.m2r)
            2'd0:    return i.alu;
            2'd1:    return i.rd;
            2'd2:    return 32'(i.pc1);
            default: return i.regd;
        endcase
    endfunction

    function automatic instr_t idle_instr();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.v     = ($urandom % 4) != 0;
        i.rw    = 1'($urandom);
        i.m2r   = 2'($urandom);
        i.br    = 2'($urandom);
        i.u     = ($urandom % 6) == 0;
        i.rd    = $urandom;
        i.regd  = $urandom;
        i.alu   = (($urandom % 4) == 0) ? 32'd0 : $urandom;
        i.rdist = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        i.idx   = 26'($urandom);
        i.pc    = W'($urandom);
        i.pc1   = W'($urandom);
        i.pc2   = W'($urandom);
        return i;
    endfunction

    // One cycle: drive inputs at the falling edge and predict what the next rising edge does.
    task automatic step(input instr_t i, input bit offer, output bit accepted);
        @(negedge clk);
        bus.in_valid      = i.v;
        bus.reg_write     = i.rw;
        bus.mem_to_reg    = i.m2r;
        bus.branch        = i.br;
        bus.uart_to_reg   = i.u;
        bus.read_data     = i.rd;
        bus.register_data = i.regd;
        bus.alu_result    = i.alu;
        bus.rdist         = i.rdist;
        bus.inst_index    = i.idx;
        bus.pc            = i.pc;
        bus.pc1           = i.pc1;
        bus.pc2           = i.pc2;
        if (busy && byte_q.size() > 0 && offer) begin
            bus.uart_rx_valid = 1'b1;
            bus.uart_rx_data  = byte_q[0];
        end else begin
            bus.uart_rx_valid = !busy && offer;
            bus.uart_rx_data  = 8'($urandom);
        end
        check("stall", 64'(bus.stall), 64'(busy));
        check("uart_rx_ready", 64'(bus.uart_rx_ready), 64'(busy));
        accepted = 1'b0;
        if (busy) begin
            if (bus.uart_rx_valid) begin
                acc_val = acc_val + 32'(byte_q[0]) * (32'd1 << (8 * nb_got));
                void'(byte_q.pop_front());
                nb_got++;
                if (nb_got == nb_need) begin
                    pend.wdata = acc_val;
                    pend.cyc   = cyc + 1;
                    sb.push_back(pend);
                    busy = 1'b0;
                end
            end
        end else if (i.v) begin
            accepted   = 1'b1;
            pend.we    = i.rw && (i.rdist != 5'd0);
            pend.waddr = i.rdist;
            pend.tgt   = model_pc(i);
            if (i.u) begin
                busy    = 1'b1;
                nb_need = i.m2r[0] ? 4 : 1;
                nb_got  = 0;
                acc_val = 32'd0;
                byte_q.delete();
                for (int k = 0; k < nb_need; k++) begin
                    if (next_bytes.size() > 0) byte_q.push_back(next_bytes.pop_front());
                    else byte_q.push_back(8'($urandom));
                end
            end else begin
                pend.wdata = model_data(i);
                pend.cyc   = cyc + 1;
                sb.push_back(pend);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_reg_we"}, 64'(bus.reg_we), 64'd0);
        check({tag, "_reg_waddr"}, 64'(bus.reg_waddr), 64'd0);
        check({tag, "_reg_wdata"}, 64'(bus.reg_wdata), 64'd0);
        check({tag, "_pc_we"}, 64'(bus.pc_we), 64'd0);
        check({tag, "_pc_target"}, 64'(bus.pc_target), 64'd0);
        check({tag, "_retired"}, 64'(bus.retired), 64'd0);
        check({tag, "_stall"}, 64'(bus.stall), 64'd0);
        check({tag, "_uart_rx_ready"}, 64'(bus.uart_rx_ready), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.in_valid      = 1'b1;
        bus.uart_rx_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        busy = 1'b0;
        byte_q.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        bus.in_valid      = 1'b0;
        bus.uart_rx_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: every retired pulse must match the oldest predicted commit, on its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.retired === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_commit: retired=1 at cycle %0d, expected none",
                                 cyc);
                    end else begin
                        e = sb.pop_front();
                        check("commit_cycle", 64'(cyc), 64'(e.cyc));
                        check("reg_we", 64'(bus.reg_we), 64'(e.we));
                        check("reg_waddr", 64'(bus.reg_waddr), 64'(e.waddr));
                        check("reg_wdata", 64'(bus.reg_wdata), 64'(e.wdata));
                        check("pc_target", 64'(bus.pc_target), 64'(e.tgt));
                        check("pc_we", 64'(bus.pc_we), 64'd1);
                    end
                end else begin
                    check("idle_strobes", 64'({bus.reg_we, bus.pc_we, bus.retired}), 64'd0);
                    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        n_total++;
                        $display("FAIL missed_commit: no retire at cycle %0d, expected one at %0d",
                                 cyc, sb[0].cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        instr_t i, nxt;
        bit     a;
        int     guard;

        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.uart_rx_valid = 1'b0; bus.uart_rx_data = 8'd0;
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("por");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // ALU result zero takes the branch, non-zero falls through; back-to-back accepts.
        i = idle_instr();
        i.v = 1'b1; i.rw = 1'b1; i.br = 2'd1; i.pc1 = 14'd2; i.pc2 = 14'd3; i.rdist = 5'd10;
        step(i, 1'b0, a);
        i.alu = 32'h5555_5555;
        step(i, 1'b0, a);
        step(idle_instr(), 1'b0, a);

        // Load to r0 with jump: write suppressed, PC still updates.
        i = idle_instr();
        i.v = 1'b1; i.rw = 1'b1; i.m2r = 2'd1; i.rd = 32'h1111_1111; i.br = 2'd2;
        i.idx = 26'h111_1111;
        step(i, 1'b0, a);
        step(idle_instr(), 1'b0, a);

        do_reset();
        repeat (3) step(idle_instr(), 1'b1, a);

        // Single UART byte after three empty cycles.
        next_bytes = '{8'hA5};
        i = idle_instr();
        i.v = 1'b1; i.u = 1'b1; i.rw = 1'b1; i.rdist = 5'd31; i.br = 2'd0; i.pc1 = 14'h123;
        step(i, 1'b0, a);
        repeat (3) step(idle_instr(), 1'b0, a);
        step(idle_instr(), 1'b1, a);
        step(idle_instr(), 1'b0, a);

        // UART word with one gap while the next instruction waits on in_valid.
        next_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        i.m2r = 2'd1; i.rdist = 5'd7; i.br = 2'd3; i.regd = 32'h0000_2abc;
        step(i, 1'b0, a);
        nxt = idle_instr();
        nxt.v = 1'b1; nxt.rw = 1'b1; nxt.rdist = 5'd3; nxt.alu = 32'hcafe_f00d; nxt.pc1 = 14'd77;
        step(nxt, 1'b1, a);
        step(nxt, 1'b0, a);
        repeat (3) step(nxt, 1'b1, a);
        guard = 0;
        a = 1'b0;
        while (!a && guard < 8) begin
            step(nxt, 1'b1, a);
            guard++;
        end
        check("held_instr_accepted", 64'(a), 64'd1);
        repeat (2) step(idle_instr(), 1'b0, a);

        // Reset in the middle of a word abandons it; a fresh word then completes.
        step(i, 1'b0, a);
        step(idle_instr(), 1'b1, a);
        step(idle_instr(), 1'b1, a);
        do_reset();
        step(idle_instr(), 1'b0, a);
        next_bytes = '{8'hde, 8'had, 8'hbe, 8'hef};
        step(i, 1'b0, a);
        repeat (6) step(idle_instr(), 1'b1, a);

        repeat (3000) step(rand_instr(), ($urandom % 3) != 0, a);

        guard = 0;
        while ((busy || sb.size() > 0) && guard < 50) begin
            step(idle_instr(), 1'b1, a);
            guard++;
        end
        step(idle_instr(), 1'b0, a);
        check("drained", 64'(sb.size()) + 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
